// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared state encodings and constants for the DDR read controller
package ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_t;

  // Each beat advances the 32-bit-word address by this many words.
  localparam int BEAT_ADDR_SCALE = 8;

endpackage

// File: rtl/ddr_rd_ctrl.sv
// rtl/ddr_rd_ctrl.sv - splits a read request into AXI bursts and returns the beats
import ddr_pkg::*;

module ddr_rd_ctrl #(
  parameter int ADDR_WIDTH = 27,
  parameter int DQ_WIDTH   = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rstn,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [LEN_WIDTH-1:0]    rd_len,
  output logic                    rd_busy,
  output logic [8*DQ_WIDTH-1:0]   rd_data,
  output logic                    rd_data_en,
  output logic                    rd_done,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [8*DQ_WIDTH-1:0]   axi_rdata,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready
);

  rd_state_t             state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] addr;
  logic [8:0]            cur_beats;
  logic [ADDR_WIDTH-1:0] addr_step;

  function automatic logic [8:0] burst_beats(input logic [LEN_WIDTH-1:0] rem);
    logic [LEN_WIDTH-1:0] b;
    b = (rem > LEN_WIDTH'(MAX_BURST)) ? LEN_WIDTH'(MAX_BURST) : rem;
    return b[8:0];
  endfunction

  function automatic logic [7:0] burst_arlen(input logic [LEN_WIDTH-1:0] rem);
    logic [8:0] beats;
    beats = burst_beats(rem) - 9'd1;
    return beats[7:0];
  endfunction

  assign cur_beats = burst_beats(remaining);
  assign addr_step = ADDR_WIDTH'(BEAT_ADDR_SCALE * int'(cur_beats));

  // rd_done is registered from the DONE state, so it trails the last rd_data_en by one cycle.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      addr        <= '0;
      rd_busy     <= 1'b0;
      rd_data     <= '0;
      rd_data_en  <= 1'b0;
      rd_done     <= 1'b0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
    end else begin
      rd_data_en <= 1'b0;
      rd_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_req) begin
            rd_busy <= 1'b1;
            if (rd_len != '0) begin
              addr        <= rd_addr;
              remaining   <= rd_len;
              axi_araddr  <= rd_addr;
              axi_arlen   <= burst_arlen(rd_len);
              axi_arvalid <= 1'b1;
              state       <= ST_ADDR;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_ADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            remaining   <= remaining - LEN_WIDTH'(cur_beats);
            addr        <= addr + addr_step;
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (axi_rvalid) begin
            rd_data    <= axi_rdata;
            rd_data_en <= 1'b1;
            if (axi_rlast) begin
              axi_rready <= 1'b0;
              if (remaining != '0) begin
                axi_araddr  <= addr;
                axi_arlen   <= burst_arlen(remaining);
                axi_arvalid <= 1'b1;
                state       <= ST_ADDR;
              end else begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          rd_done <= 1'b1;
          rd_busy <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
